// File: rtl/present_la_if.sv
// present_la_if: logic-analyzer command bus for the PRESENT-64 engine.
// The master side (LA / bench) drives address, data and the write strobe;
// the slave side (engine) returns registered read data and status flags.
interface present_la_if #(
   parameter int WORD_W = 32
) ();
   logic [4:0]        cmd_addr_i;
   logic [WORD_W-1:0] cmd_data_i;
   logic              cmd_wr_i;
   logic [WORD_W-1:0] rd_data_o;
   logic              busy_o;
   logic              done_o;
   logic              irq_o;

   modport master (
      output cmd_addr_i, cmd_data_i, cmd_wr_i,
      input  rd_data_o, busy_o, done_o, irq_o
   );

   modport slave (
      input  cmd_addr_i, cmd_data_i, cmd_wr_i,
      output rd_data_o, busy_o, done_o, irq_o
   );
endinterface

// File: rtl/present_la_engine.sv
// present_la_engine: iterative PRESENT-64 encryption engine behind a
// word-addressed register file written from the logic-analyzer bus.
// One round per clock; START to done takes ROUNDS+1 cycles.
// Build option: define PRESENT_KEY128_EN for a 128-bit key schedule,
// otherwise the 80-bit key schedule is used.
module present_la_engine #(
   parameter int WORD_W = 32,
   parameter int ROUNDS = 31
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   present_la_if.slave bus
);

`ifdef PRESENT_KEY128_EN
   localparam int KEY_BITS = 128;
`else
   localparam int KEY_BITS = 80;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FINAL = 2'd2
   } fsm_e;

   // ---------------- datapath helper functions ----------------
   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
         4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
         4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
         4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  4'hF: sbox = 4'h2;
         default: sbox = 4'h0;
      endcase
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] x);
      for (int n = 0; n < 16; n++) begin
         sbox_layer[4*n +: 4] = sbox(x[4*n +: 4]);
      end
   endfunction

   // Bit i moves to (16*i) mod 63; bit 63 stays in place.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      for (int i = 0; i < 63; i++) begin
         p_layer[(16 * i) % 63] = x[i];
      end
      p_layer[63] = x[63];
   endfunction

   function automatic logic [KEY_BITS-1:0] key_update(input logic [KEY_BITS-1:0] k,
                                                      input logic [4:0]          rc);
      logic [KEY_BITS-1:0] r;
      r = {k[KEY_BITS-62:0], k[KEY_BITS-1:KEY_BITS-61]};
`ifdef PRESENT_KEY128_EN
      r[127:124] = sbox(r[127:124]);
      r[123:120] = sbox(r[123:120]);
      r[66:62]   = r[66:62] ^ rc;
`else
      r[79:76]   = sbox(r[79:76]);
      r[19:15]   = r[19:15] ^ rc;
`endif
      key_update = r;
   endfunction

   // Extract bus word idx from a 64-bit value; out-of-range words read as 0.
   function automatic logic [WORD_W-1:0] word_of64(input logic [63:0] v, input logic [2:0] idx);
      word_of64 = {WORD_W{1'b0}};
      for (int i = 0; i < 64; i++) begin
         word_of64[i % WORD_W] = ((i / WORD_W) == int'(idx)) ? v[i] : word_of64[i % WORD_W];
      end
   endfunction

   // Extract bus word idx from the key; padding bits and unused words read as 0.
   function automatic logic [WORD_W-1:0] word_of_key(input logic [KEY_BITS-1:0] v,
                                                     input logic [2:0]          idx);
      word_of_key = {WORD_W{1'b0}};
      for (int i = 0; i < KEY_BITS; i++) begin
         word_of_key[i % WORD_W] = ((i / WORD_W) == int'(idx)) ? v[i] : word_of_key[i % WORD_W];
      end
   endfunction

   // ---------------- state ----------------
   fsm_e                fsm_q, fsm_d;
   logic                wr_prev_q;
   logic [63:0]         text_q, text_d;
   logic [KEY_BITS-1:0] key_q, key_d;
   logic [63:0]         state_q, state_d;
   logic [KEY_BITS-1:0] kreg_q, kreg_d;
   logic [4:0]          rc_q, rc_d;
   logic [63:0]         result_q, result_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                irq_q, irq_d;
   logic [WORD_W-1:0]   rd_data_q, rd_data_d;

   // ---------------- decode ----------------
   logic [4:0] addr_s;
   logic       wr_edge_s;
   logic       wr_text_s;
   logic       wr_key_s;
   logic       start_s;
   logic       clr_s;
   logic [63:0] round_key_s;

   assign addr_s      = bus.cmd_addr_i;
   assign wr_edge_s   = bus.cmd_wr_i & ~wr_prev_q;
   assign wr_text_s   = wr_edge_s & (addr_s[4:2] == 3'b000);
   assign wr_key_s    = wr_edge_s & (addr_s[4:3] == 2'b01);
   assign start_s     = wr_edge_s & (addr_s == 5'h10) & bus.cmd_data_i[0];
   assign clr_s       = wr_edge_s & (addr_s == 5'h10) & bus.cmd_data_i[1];
   assign round_key_s = kreg_q[KEY_BITS-1 -: 64];

   assign bus.rd_data_o = rd_data_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.irq_o     = irq_q;

   // Load registers: TEXT and KEY words land on the addressed bit slice.
   always_comb begin
      text_d = text_q;
      key_d  = key_q;
      for (int i = 0; i < 64; i++) begin
         text_d[i] = (wr_text_s && ((i / WORD_W) == int'(addr_s[2:0])))
                     ? bus.cmd_data_i[i % WORD_W] : text_q[i];
      end
      for (int i = 0; i < KEY_BITS; i++) begin
         key_d[i] = (wr_key_s && ((i / WORD_W) == int'(addr_s[2:0])))
                    ? bus.cmd_data_i[i % WORD_W] : key_q[i];
      end
   end

   // Read mux: next read word for the currently presented address.
   always_comb begin
      rd_data_d = {WORD_W{1'b0}};
      case (addr_s[4:3])
         2'b00:   rd_data_d = addr_s[2] ? {WORD_W{1'b0}} : word_of64(text_q, addr_s[2:0]);
         2'b01:   rd_data_d = word_of_key(key_q, addr_s[2:0]);
         2'b10:   rd_data_d = (addr_s == 5'h11) ? {{(WORD_W-2){1'b0}}, done_q, busy_q}
                                                : {WORD_W{1'b0}};
         2'b11:   rd_data_d = addr_s[2] ? {WORD_W{1'b0}} : word_of64(result_q, addr_s[2:0]);
         default: rd_data_d = {WORD_W{1'b0}};
      endcase
   end

   // Engine FSM next state: load on START, one round per RUN cycle, final key add.
   always_comb begin
      fsm_d    = fsm_q;
      state_d  = state_q;
      kreg_d   = kreg_q;
      rc_d     = rc_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = done_q;
      irq_d    = 1'b0;
      case (fsm_q)
         ST_IDLE: begin
            if (start_s) begin
               fsm_d   = ST_RUN;
               state_d = text_q;
               kreg_d  = key_q;
               rc_d    = 5'd1;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end else if (clr_s) begin
               done_d = 1'b0;
            end else begin
               fsm_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            state_d = p_layer(sbox_layer(state_q ^ round_key_s));
            kreg_d  = key_update(kreg_q, rc_q);
            rc_d    = (rc_q == 5'd31) ? rc_q : rc_q + 5'd1;
            if (rc_q == 5'(ROUNDS)) begin
               fsm_d = ST_FINAL;
            end else begin
               fsm_d = ST_RUN;
            end
         end
         ST_FINAL: begin
            result_d = state_q ^ round_key_s;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            irq_d    = 1'b1;
            fsm_d    = ST_IDLE;
         end
         default: begin
            fsm_d  = ST_IDLE;
            busy_d = 1'b0;
         end
      endcase
   end

   // State register: every register clears on reset, including RESULT.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         fsm_q     <= ST_IDLE;
         wr_prev_q <= 1'b0;
         text_q    <= 64'd0;
         key_q     <= {KEY_BITS{1'b0}};
         state_q   <= 64'd0;
         kreg_q    <= {KEY_BITS{1'b0}};
         rc_q      <= 5'd0;
         result_q  <= 64'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         irq_q     <= 1'b0;
         rd_data_q <= {WORD_W{1'b0}};
      end else begin
         fsm_q     <= fsm_d;
         wr_prev_q <= bus.cmd_wr_i;
         text_q    <= text_d;
         key_q     <= key_d;
         state_q   <= state_d;
         kreg_q    <= kreg_d;
         rc_q      <= rc_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         irq_q     <= irq_d;
         rd_data_q <= rd_data_d;
      end
   end

endmodule

// File: tb/tb_present_la_engine.sv
// tb_present_la_engine: directed self-checking bench for present_la_engine
// (WORD_W=32, ROUNDS=31). Expected ciphertexts are published PRESENT vectors.
module tb_present_la_engine;

`ifdef PRESENT_KEY128_EN
   localparam logic [63:0] ZERO_CT = 64'h96DB702A2E6900AF;
`else
   localparam logic [63:0] ZERO_CT = 64'h5579C1387B228445;
`endif
   localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   present_la_if #(.WORD_W(32)) bus ();

   present_la_engine #(.WORD_W(32), .ROUNDS(31)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cmd_addr_i = a;
      bus.cmd_data_i = d;
      bus.cmd_wr_i   = 1'b1;
      @(negedge clk);
      bus.cmd_wr_i   = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.cmd_addr_i = a;
      @(negedge clk);
      d = bus.rd_data_o;
   endtask

   task automatic read_result(output logic [63:0] r);
      logic [31:0] lo, hi;
      do_read(5'h18, lo);
      do_read(5'h19, hi);
      r = {hi, lo};
   endtask

   task automatic load(input logic [63:0] t, input logic [127:0] k);
      do_write(5'h00, t[31:0]);
      do_write(5'h01, t[63:32]);
      do_write(5'h08, k[31:0]);
      do_write(5'h09, k[63:32]);
      do_write(5'h0A, k[95:64]);
      do_write(5'h0B, k[127:96]);
   endtask

   // Issues START, holds the strobe for 'hold' cycles and watches 45 cycles.
   // mode 1: TEXT writes and a second START mid-run; mode 2: reset at cycle 15.
   task automatic run_op(input int hold, input int mode, output int lat, output int irqs,
                         output logic [31:0] mid_rd, output logic mid_busy);
      @(negedge clk);
      bus.cmd_addr_i = 5'h10;
      bus.cmd_data_i = 32'h1;
      bus.cmd_wr_i   = 1'b1;
      @(posedge clk);
      lat = 0; irqs = 0; mid_rd = 32'h0; mid_busy = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         @(posedge clk);
         #1;
         if (bus.irq_o) irqs++;
         if (bus.done_o && lat == 0) lat = c;
         if (c == hold) bus.cmd_wr_i = 1'b0;
         if (c == 1) bus.cmd_addr_i = 5'h18;
         if (c == 2) begin
            mid_rd   = bus.rd_data_o;
            mid_busy = bus.busy_o;
         end
         if (mode == 1) begin
            case (c)
               3:  begin bus.cmd_addr_i = 5'h00; bus.cmd_data_i = 32'hFFFF_FFFF; bus.cmd_wr_i = 1'b1; end
               4:  bus.cmd_wr_i = 1'b0;
               6:  begin bus.cmd_addr_i = 5'h01; bus.cmd_wr_i = 1'b1; end
               7:  bus.cmd_wr_i = 1'b0;
               10: begin bus.cmd_addr_i = 5'h10; bus.cmd_data_i = 32'h1; bus.cmd_wr_i = 1'b1; end
               11: bus.cmd_wr_i = 1'b0;
               default: ;
            endcase
         end
         if (mode == 2 && c == 15) begin
            rst_n = 1'b0;
            #1;
            break;
         end
      end
      bus.cmd_wr_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
      total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
      total++; if (bus.irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", bus.irq_o); end
      total++; if (bus.rd_data_o !== 32'h0) begin bad++; $display("FAIL reset_rd got=%h exp=0", bus.rd_data_o); end
      do_read(5'h11, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
   endtask

   task automatic test_zero_vector();
      int lat, irqs; logic [31:0] m; logic mb; logic [63:0] r;
      load(64'h0, 128'h0);
      run_op(1, 0, lat, irqs, m, mb);
      total++; if (lat !== 32) begin bad++; $display("FAIL zero_latency got=%0d exp=32", lat); end
      total++; if (irqs !== 1) begin bad++; $display("FAIL zero_irq_count got=%0d exp=1", irqs); end
      total++; if (mb !== 1'b1) begin bad++; $display("FAIL zero_busy_mid got=%b exp=1", mb); end
      total++; if (bus.done_o !== 1'b1) begin bad++; $display("FAIL zero_done_sticky got=%b exp=1", bus.done_o); end
      read_result(r);
      total++; if (r !== ZERO_CT) begin bad++; $display("FAIL zero_result got=%h exp=%h", r, ZERO_CT); end
   endtask

   task automatic test_ones_vectors();
      int lat, irqs; logic [31:0] m; logic mb; logic [63:0] r;
      load(64'h0, {ONES64, ONES64});
      run_op(1, 0, lat, irqs, m, mb);
      read_result(r);
      total++; if (r !== 64'hE72C46C0F5945049) begin bad++; $display("FAIL key1_result got=%h exp=e72c46c0f5945049", r); end
      load(ONES64, {ONES64, ONES64});
      run_op(1, 0, lat, irqs, m, mb);
      total++; if (m !== 32'hF5945049) begin bad++; $display("FAIL result_during_run got=%h exp=f5945049", m); end
      read_result(r);
      total++; if (r !== 64'h3333DCD3213210D2) begin bad++; $display("FAIL all1_result got=%h exp=3333dcd3213210d2", r); end
   endtask

   task automatic test_busy_writes();
      int lat, irqs; logic [31:0] m; logic mb; logic [63:0] r;
      load(64'h0, {ONES64, ONES64});
      run_op(1, 1, lat, irqs, m, mb);
      total++; if (lat !== 32) begin bad++; $display("FAIL busy_start_latency got=%0d exp=32", lat); end
      total++; if (irqs !== 1) begin bad++; $display("FAIL busy_start_irqs got=%0d exp=1", irqs); end
      read_result(r);
      total++; if (r !== 64'hE72C46C0F5945049) begin bad++; $display("FAIL busy_run_result got=%h exp=e72c46c0f5945049", r); end
      run_op(1, 0, lat, irqs, m, mb);
      read_result(r);
      total++; if (r !== 64'h3333DCD3213210D2) begin bad++; $display("FAIL new_text_result got=%h exp=3333dcd3213210d2", r); end
   endtask

   task automatic test_held_strobe();
      int lat, irqs; logic [31:0] m, d; logic mb;
      run_op(5, 0, lat, irqs, m, mb);
      total++; if (irqs !== 1) begin bad++; $display("FAIL held_irqs got=%0d exp=1", irqs); end
      total++; if (lat !== 32) begin bad++; $display("FAIL held_latency got=%0d exp=32", lat); end
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL held_busy_end got=%b exp=0", bus.busy_o); end
      do_write(5'h10, 32'h2);
      total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL clr_done got=%b exp=0", bus.done_o); end
      do_read(5'h11, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL clr_status got=%h exp=0", d); end
   endtask

   task automatic test_reset_mid_run();
      int lat, irqs; logic [31:0] m; logic mb; logic [63:0] r;
      run_op(1, 2, lat, irqs, m, mb);
      total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_run_busy got=%b exp=0", bus.busy_o); end
      total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL rst_run_done got=%b exp=0", bus.done_o); end
      total++; if (bus.rd_data_o !== 32'h0) begin bad++; $display("FAIL rst_run_rd got=%h exp=0", bus.rd_data_o); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      read_result(r);
      total++; if (r !== 64'h0) begin bad++; $display("FAIL rst_result_clear got=%h exp=0", r); end
      load(64'h0, 128'h0);
      run_op(1, 0, lat, irqs, m, mb);
      total++; if (lat !== 32) begin bad++; $display("FAIL rerun_latency got=%0d exp=32", lat); end
      read_result(r);
      total++; if (r !== ZERO_CT) begin bad++; $display("FAIL rerun_result got=%h exp=%h", r, ZERO_CT); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.cmd_addr_i = 5'h0;
      bus.cmd_data_i = 32'h0;
      bus.cmd_wr_i   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      test_reset();
      test_zero_vector();
`ifndef PRESENT_KEY128_EN
      test_ones_vectors();
      test_busy_writes();
`endif
      test_held_strobe();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
